data_memory_responder: RTL

//  Responder end of the processor's data-memory port. Takes address, write data and write strobe;

---
 rtl/processor_mem_pkg.sv | 37 +++
 rtl/dmem_ram_array.sv | 35 +++
 rtl/data_memory_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/processor_mem_pkg.sv
// rtl/processor_mem_pkg.sv - shared types, MMIO offsets and address decode for the data-memory responder
//
// Contents:
//   region_t       address region classification (RAM, MMIO window, out of range)
//   MMIO_*         byte offsets of the MMIO registers inside the window
//   decode_region  classifies a byte address given the MMIO base (upper half) and RAM depth in words
package processor_mem_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_OOR
    } region_t;

    localparam logic [15:0] MMIO_LED   = 16'h0000;
    localparam logic [15:0] MMIO_CYC   = 16'h0004;
    localparam logic [15:0] MMIO_WRC   = 16'h0008;
    localparam logic [15:0] MMIO_ERR   = 16'h000C;
    localparam logic [15:0] MMIO_FADDR = 16'h0010;

    // The MMIO window takes priority over RAM so a very deep RAM can never
    // shadow the register window.
    function automatic region_t decode_region(
        input logic [31:0] addr,
        input logic [15:0] mmio_hi,
        input logic [31:0] depth_words
    );
        if (addr[31:16] == mmio_hi) begin
            return REG_MMIO;
        end else if ({2'b00, addr[31:2]} < depth_words) begin
            return REG_RAM;
        end else begin
            return REG_OOR;
        end
    endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// rtl/dmem_ram_array.sv - word RAM with combinational read and synchronous write
//
// Ports:
//   clock  in   rising-edge clock
//   we     in   write enable, sampled on the rising edge
//   waddr  in   word write address
//   wdata  in   32-bit write data
//   raddr  in   word read address
//   rdata  out  32-bit read data, combinational from raddr
//
// Contents are not reset; a word is undefined until first written.
module dmem_ram_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read sees the pre-edge contents during a same-address write, which
    // gives the old-value-until-the-edge behaviour at the top level.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - data-memory port responder: word RAM plus LED/counter/error MMIO window
//
// Optional feature macro: DMEM_ERR_CAPTURE_EN (adds fault_addr capture register at MMIO +0x10).
//
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   addr        in   32-bit byte address
//   write_data  in   32-bit store data
//   mem_write   in   store strobe, sampled on the rising edge
//   read_data   out  32-bit load data, combinational from addr
//   leds        out  LED_W-bit registered LED value
//   err         out  sticky access-fault flag
module data_memory_responder
    import processor_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LED_W     = 8,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    input  logic             mem_write,
    output logic [31:0]      read_data,
    output logic [LED_W-1:0] leds,
    output logic             err
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_WORDS = 32'(DEPTH);

    // ------------------------------------------------------------------
    // Decode and fault classification
    // ------------------------------------------------------------------
    region_t     region;
    logic [15:0] mmio_off;
    logic        misaligned;
    logic        mmio_mapped;
    logic        fault;
    logic        wr_ok;
    logic        ram_we;
    logic        mmio_we;

    assign region     = decode_region(addr, MMIO_BASE[31:16], DEPTH_WORDS);
    assign mmio_off   = addr[15:0];
    assign misaligned = (addr[1:0] != 2'b00);

    always_comb begin
        mmio_mapped = 1'b0;
        unique case (mmio_off)
            MMIO_LED, MMIO_CYC, MMIO_WRC, MMIO_ERR: mmio_mapped = 1'b1;
`ifdef DMEM_ERR_CAPTURE_EN
            MMIO_FADDR:                             mmio_mapped = 1'b1;
`endif
            default:                                mmio_mapped = 1'b0;
        endcase
    end

    assign fault = misaligned
                 || (region == REG_OOR)
                 || ((region == REG_MMIO) && !mmio_mapped);

    // Writes are ignored while reset is held; the RAM has no reset of its
    // own so its enable must be gated explicitly.
    assign wr_ok   = mem_write && !fault && reset_n;
    assign ram_we  = wr_ok && (region == REG_RAM);
    assign mmio_we = wr_ok && (region == REG_MMIO);

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_rdata;

    assign ram_idx = addr[AW+1:2];

    dmem_ram_array #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_idx),
        .wdata (write_data),
        .raddr (ram_idx),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // MMIO registers and counters
    // ------------------------------------------------------------------
    logic [LED_W-1:0] leds_q,      leds_d;
    logic [31:0]      cycle_cnt_q, cycle_cnt_d;
    logic [31:0]      wr_cnt_q,    wr_cnt_d;
    logic             err_q,       err_d;
    logic             fault_wr;

    assign fault_wr = mem_write && fault;

    always_comb begin
        leds_d      = leds_q;
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        wr_cnt_d    = wr_cnt_q;
        err_d       = err_q;

        if (ram_we && (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end

        // An MMIO write and a RAM write are mutually exclusive, so the
        // counter clears below never race the wr_cnt increment above.
        if (mmio_we) begin
            unique case (mmio_off)
                MMIO_LED: leds_d      = write_data[LED_W-1:0];
                MMIO_CYC: cycle_cnt_d = 32'd0;
                MMIO_WRC: wr_cnt_d    = 32'd0;
                MMIO_ERR: if (write_data[0]) err_d = 1'b0;
                default:  ;
            endcase
        end

        // A faulting write is never an accepted write, so set and clear
        // of err cannot both fire on the same edge.
        if (fault_wr) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            leds_q      <= '0;
            cycle_cnt_q <= 32'd0;
            wr_cnt_q    <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            leds_q      <= leds_d;
            cycle_cnt_q <= cycle_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            err_q       <= err_d;
        end
    end

`ifdef DMEM_ERR_CAPTURE_EN
    // Captures only the first faulting write of an error episode; the value
    // survives an err clear so software can read it after acknowledging.
    logic [31:0] fault_addr_q, fault_addr_d;

    always_comb begin
        fault_addr_d = fault_addr_q;
        if (fault_wr && !err_q) begin
            fault_addr_d = addr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_addr_q <= 32'd0;
        end else begin
            fault_addr_q <= fault_addr_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        read_data = 32'd0;
        if (!fault) begin
            unique case (region)
                REG_RAM: read_data = ram_rdata;
                REG_MMIO: begin
                    unique case (mmio_off)
                        MMIO_LED:   read_data = 32'(leds_q);
                        MMIO_CYC:   read_data = cycle_cnt_q;
                        MMIO_WRC:   read_data = wr_cnt_q;
                        MMIO_ERR:   read_data = {31'd0, err_q};
`ifdef DMEM_ERR_CAPTURE_EN
                        MMIO_FADDR: read_data = fault_addr_q;
`endif
                        default:    read_data = 32'd0;
                    endcase
                end
                default: read_data = 32'd0;
            endcase
        end
    end

    assign leds = leds_q;
    assign err  = err_q;

endmodule
